// File: rtl/hpdl_pkg.sv
// rtl/hpdl_pkg.sv - shared constants, refresh state type and character sanitiser for the HPDL-1414 driver
package hpdl_pkg;

    localparam logic [6:0] CH_SPACE  = 7'h20;
    localparam logic [6:0] CH_CURSOR = 7'h5F;
    localparam logic [6:0] CH_CR     = 7'h0D;
    localparam logic [6:0] CH_FF     = 7'h0C;
    localparam logic [6:0] CH_BS     = 7'h08;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } refresh_state_e;

    function automatic logic is_control(input logic [6:0] c);
        return (c < 7'h20);
    endfunction

    // Lower-case folds onto the upper-case glyphs; anything the HPDL-1414 cannot show becomes a space.
    function automatic logic [6:0] fold_char(input logic [6:0] c);
        logic [6:0] r;
        if (c >= 7'h61 && c <= 7'h7A) begin
            r = c - 7'h20;
        end else if (c >= 7'h20 && c <= 7'h5F) begin
            r = c;
        end else begin
            r = CH_SPACE;
        end
        return r;
    endfunction

endpackage

// File: rtl/hpdl_display_ctrl_if.sv
// rtl/hpdl_display_ctrl_if.sv - byte input stream with valid/ready handshake and entry-mode select
interface hpdl_display_ctrl_if;

    logic       IN_VALID;
    logic [7:0] IN_DATA;
    logic       IN_READY;
    logic       MODE;

    modport master (
        output IN_VALID,
        output IN_DATA,
        output MODE,
        input  IN_READY
    );

    modport slave (
        input  IN_VALID,
        input  IN_DATA,
        input  MODE,
        output IN_READY
    );

endinterface

// File: rtl/hpdl_char_buffer.sv
// rtl/hpdl_char_buffer.sv - character store with scroll/direct entry, cursor, clear sequencer and read port
// Optional HPDL_CURSOR_BLINK_EN substitutes the cursor glyph on the read port while blink_i is high.
module hpdl_char_buffer
    import hpdl_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    hpdl_display_ctrl_if.slave   in_if,
    input  logic [IDX_W-1:0]     rd_idx_i,
`ifdef HPDL_CURSOR_BLINK_EN
    input  logic                 blink_i,
`endif
    output logic [6:0]           rd_data_o
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    logic [6:0]       mem_q [DEPTH];
    logic [IDX_W-1:0] cursor_q;
    logic [IDX_W-1:0] clr_idx_q;
    logic             clearing_q;

    logic [6:0]       c_raw;
    logic [6:0]       c_chr;
    logic             c_ctrl;
    logic             accept;

    assign c_raw          = in_if.IN_DATA[6:0];
    assign c_chr          = fold_char(c_raw);
    assign c_ctrl         = is_control(c_raw);
    assign accept         = in_if.IN_VALID && !clearing_q;
    assign in_if.IN_READY = !clearing_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int p = 0; p < DEPTH; p++) begin
                mem_q[p] <= CH_SPACE;
            end
            cursor_q   <= '0;
            clr_idx_q  <= '0;
            clearing_q <= 1'b0;
        end else if (clearing_q) begin
            mem_q[clr_idx_q] <= CH_SPACE;
            clr_idx_q        <= clr_idx_q + 1'b1;
            if (clr_idx_q == LAST) begin
                clearing_q <= 1'b0;
            end
        end else if (accept) begin
            if (c_ctrl) begin
                // Scroll mode honours only form-feed; the cursor codes are meaningless there.
                if (c_raw == CH_FF) begin
                    clearing_q <= 1'b1;
                    clr_idx_q  <= '0;
                    if (in_if.MODE) begin
                        cursor_q <= '0;
                    end
                end else if (in_if.MODE && c_raw == CH_CR) begin
                    cursor_q <= '0;
                end else if (in_if.MODE && c_raw == CH_BS && cursor_q != '0) begin
                    cursor_q <= cursor_q - 1'b1;
                end
            end else if (in_if.MODE) begin
                mem_q[cursor_q] <= c_chr;
                cursor_q        <= (cursor_q == LAST) ? '0 : cursor_q + 1'b1;
            end else begin
                for (int p = 0; p < DEPTH - 1; p++) begin
                    mem_q[p] <= mem_q[p+1];
                end
                mem_q[DEPTH-1] <= c_chr;
            end
        end
    end

`ifdef HPDL_CURSOR_BLINK_EN
    assign rd_data_o = (in_if.MODE && blink_i && rd_idx_i == cursor_q) ? CH_CURSOR : mem_q[rd_idx_i];
`else
    assign rd_data_o = mem_q[rd_idx_i];
`endif

endmodule

// File: rtl/hpdl_display_ctrl.sv
// rtl/hpdl_display_ctrl.sv - HPDL-1414 chain driver: refresh divider, write-cycle FSM and pin registers
// Optional HPDL_CURSOR_BLINK_EN adds a frame counter that blinks the cursor position in direct mode.
module hpdl_display_ctrl
    import hpdl_pkg::*;
#(
    parameter int NUM_MODULES = 4,
    parameter int REFRESH_DIV = 2048,
    parameter int SETUP_CYC   = 2,
    parameter int WR_CYC      = 4,
    parameter int HOLD_CYC    = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    hpdl_display_ctrl_if.slave     in_if,
    output logic [6:0]             HPDL_D,
    output logic [1:0]             HPDL_A,
    output logic [NUM_MODULES-1:0] HPDL_WR_N,
    output logic                   FRAME_DONE
);

    localparam int DEPTH  = NUM_MODULES * 4;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int DIV_W  = $clog2(REFRESH_DIV);
    localparam int MAX_PH = (SETUP_CYC > WR_CYC)
                          ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                          : ((WR_CYC > HOLD_CYC) ? WR_CYC : HOLD_CYC);
    localparam int CNT_W  = $clog2(MAX_PH + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    if (NUM_MODULES < 1) begin : g_bad_modules
        $error("NUM_MODULES must be at least 1");
    end
    if (SETUP_CYC < 1 || WR_CYC < 1 || HOLD_CYC < 1) begin : g_bad_phase
        $error("SETUP_CYC, WR_CYC and HOLD_CYC must each be at least 1");
    end
    if (REFRESH_DIV <= SETUP_CYC + WR_CYC + HOLD_CYC + 1) begin : g_bad_div
        $error("REFRESH_DIV too short to fit one digit write cycle");
    end

    logic [DIV_W-1:0]       div_q;
    logic [DIV_W-1:0]       div_d;
    logic                   tick;
    refresh_state_e         state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [6:0]             hpdl_d_q;
    logic [1:0]             hpdl_a_q;
    logic [NUM_MODULES-1:0] wr_n_q;
    logic                   frame_done_q;
    logic [6:0]             rd_data;

    assign tick  = (div_q == DIV_W'(REFRESH_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

`ifdef HPDL_CURSOR_BLINK_EN
    logic [4:0] frame_cnt_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            frame_cnt_q <= '0;
        end else if (frame_done_q) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end
`endif

    hpdl_char_buffer #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .in_if     (in_if),
        .rd_idx_i  (idx_q),
`ifdef HPDL_CURSOR_BLINK_EN
        .blink_i   (frame_cnt_q[4]),
`endif
        .rd_data_o (rd_data)
    );

    // A/D are captured once on SETUP entry so a buffer write mid-cycle never disturbs the pins.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            hpdl_a_q     <= 2'b11;
            hpdl_d_q     <= CH_SPACE;
            wr_n_q       <= '1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_q  <= SETUP;
                        cnt_q    <= '0;
                        hpdl_a_q <= ~idx_q[1:0];
                        hpdl_d_q <= rd_data;
                    end
                end
                SETUP: begin
                    if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                        state_q <= STROBE;
                        cnt_q   <= '0;
                        wr_n_q  <= ~(NUM_MODULES'(1) << (idx_q >> 2));
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt_q == CNT_W'(WR_CYC - 1)) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                        wr_n_q  <= '1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                        state_q      <= IDLE;
                        cnt_q        <= '0;
                        idx_q        <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
                        frame_done_q <= (idx_q == LAST);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign HPDL_D     = hpdl_d_q;
    assign HPDL_A     = hpdl_a_q;
    assign HPDL_WR_N  = wr_n_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_hpdl_display_ctrl.sv
// tb/tb_hpdl_display_ctrl.sv - randomized bench for hpdl_display_ctrl against a behavioural model
module tb_hpdl_display_ctrl;

    localparam int NM    = 2;
    localparam int DIV   = 8;
    localparam int SC    = 1;
    localparam int WC    = 2;
    localparam int HC    = 1;
    localparam int DEPTH = NM * 4;

    logic          CLK   = 1'b0;
    logic          RST_N = 1'b0;
    logic [6:0]    HPDL_D;
    logic [1:0]    HPDL_A;
    logic [NM-1:0] HPDL_WR_N;
    logic          FRAME_DONE;

    hpdl_display_ctrl_if in_if ();

    hpdl_display_ctrl #(
        .NUM_MODULES (NM),
        .REFRESH_DIV (DIV),
        .SETUP_CYC   (SC),
        .WR_CYC      (WC),
        .HOLD_CYC    (HC)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .in_if      (in_if),
        .HPDL_D     (HPDL_D),
        .HPDL_A     (HPDL_A),
        .HPDL_WR_N  (HPDL_WR_N),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Behavioural model: character store plus refresh timing derived from edge count since reset.
    logic [6:0]    mbuf [DEPTH];
    int            mcur = 0;
    int            mclr = 0;
    int            me   = -1;
    logic [1:0]    exp_a   = 2'b11;
    logic [6:0]    exp_d   = 7'h20;
    logic [NM-1:0] exp_wr  = '1;
    logic          exp_fd  = 1'b0;
    logic          exp_rdy = 1'b1;
    bit            chk_en  = 0;

    function automatic logic [6:0] model_fold(input logic [6:0] c);
        if (c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
        if (c >= 7'h20 && c <= 7'h5F) return c;
        return 7'h20;
    endfunction

    task automatic model_byte(input logic [7:0] b, input logic m);
        logic [6:0] c;
        c = b[6:0];
        if (c < 7'h20) begin
            if (c == 7'h0C) begin
                mclr = DEPTH;
                if (m) mcur = 0;
            end else if (m && c == 7'h0D) begin
                mcur = 0;
            end else if (m && c == 7'h08 && mcur > 0) begin
                mcur = mcur - 1;
            end
        end else if (m) begin
            mbuf[mcur] = model_fold(c);
            mcur = (mcur + 1) % DEPTH;
        end else begin
            for (int p = 0; p < DEPTH - 1; p++) mbuf[p] = mbuf[p+1];
            mbuf[DEPTH-1] = model_fold(c);
        end
    endtask

    initial begin
        int j, off, pos;
        forever begin
            @(posedge CLK);
            if (!RST_N) begin
                for (int p = 0; p < DEPTH; p++) mbuf[p] = 7'h20;
                mcur = 0; mclr = 0; me = -1;
                exp_a = 2'b11; exp_d = 7'h20; exp_wr = '1; exp_fd = 1'b0; exp_rdy = 1'b1;
            end else begin
                me++;
                if (me >= DIV - 1) begin
                    j   = (me - (DIV - 1)) / DIV;
                    off = (me - (DIV - 1)) % DIV;
                    pos = j % DEPTH;
                    if (off == 0) begin
                        exp_a = 2'(3 - pos % 4);
                        exp_d = mbuf[pos];
                    end
                    exp_wr = '1;
                    if (off >= SC && off < SC + WC) exp_wr[pos/4] = 1'b0;
                    exp_fd = (off == SC + WC + HC) && (pos == DEPTH - 1);
                end
                if (mclr > 0) begin
                    mbuf[DEPTH-mclr] = 7'h20;
                    mclr--;
                end else if (in_if.IN_VALID) begin
                    model_byte(in_if.IN_DATA, in_if.MODE);
                end
                exp_rdy = (mclr == 0);
            end
            chk_en = 1;
        end
    end

    logic [10:0]   sq [$];
    logic [NM-1:0] prev_wr = '1;
    int            first_fd_e = -1;

    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                check("wr_n", 32'(HPDL_WR_N), 32'(exp_wr));
                check("addr", 32'(HPDL_A), 32'(exp_a));
                check("data", 32'(HPDL_D), 32'(exp_d));
                check("frame_done", 32'(FRAME_DONE), 32'(exp_fd));
                check("in_ready", 32'(in_if.IN_READY), 32'(exp_rdy));
                if (HPDL_WR_N != '1 && prev_wr == '1) sq.push_back({HPDL_WR_N, HPDL_A, HPDL_D});
                if (FRAME_DONE === 1'b1 && first_fd_e < 0) first_fd_e = me;
                prev_wr = HPDL_WR_N;
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic m);
        logic r;
        bit   done;
        done = 0;
        @(negedge CLK); #1;
        in_if.IN_VALID = 1'b1; in_if.IN_DATA = b; in_if.MODE = m;
        for (int k = 0; k < 64 && !done; k++) begin
            r = in_if.IN_READY;
            @(posedge CLK);
            if (r) done = 1;
            else begin @(negedge CLK); #1; end
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        #1 in_if.IN_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_strobes(input int n);
        int k;
        k = 0;
        while (sq.size() < n && k < 400) begin @(negedge CLK); k++; end
        if (sq.size() < n) check("strobe_timeout", 32'(sq.size()), 32'(n));
    endtask

    task automatic pulse_reset(input int n);
        @(negedge CLK); #1 RST_N = 1'b0;
        repeat (n) @(negedge CLK);
        #1 RST_N = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] t1_exp [8];
        logic [7:0]  txt    [9];
        logic [6:0]  last_d;
        logic [7:0]  b;
        int          lowc, r, waited;
        bit          allsp;

        in_if.IN_VALID = 1'b0; in_if.IN_DATA = 8'h00; in_if.MODE = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_wr_n", 32'(HPDL_WR_N), 32'h3);
        check("reset_addr", 32'(HPDL_A), 32'h3);
        check("reset_data", 32'(HPDL_D), 32'h20);
        check("reset_ready", 32'(in_if.IN_READY), 32'h1);
        sq.delete();
        #1 RST_N = 1'b1;

        // Scenario 1: idle frame after reset
        wait_strobes(8);
        for (int p = 0; p < 8; p++) t1_exp[p] = {(p < 4) ? 2'b10 : 2'b01, 2'(3 - p % 4), 7'h20};
        for (int p = 0; p < 8 && p < sq.size(); p++) check("idle_frame_strobe", 32'(sq[p]), 32'(t1_exp[p]));
        idle(10);
        check("first_frame_done_edge", 32'(first_fd_e), 32'd67);

        // Scenario 2: scroll "HI"
        send(8'h48, 1'b0); send(8'h49, 1'b0);
        check("model_scroll_6", 32'(mbuf[6]), 32'h48);
        check("model_scroll_7", 32'(mbuf[7]), 32'h49);
        sq.delete();
        wait_strobes(16);
        last_d = 7'h00;
        foreach (sq[i]) if (sq[i][10:7] == 4'b0101) last_d = sq[i][6:0];
        check("scroll_pos6_pins", 32'(last_d), 32'h48);

        // Scenario 3: direct "abc", backspace, 'Z'
        send(8'h0D, 1'b1);
        send(8'h61, 1'b1); send(8'h62, 1'b1); send(8'h63, 1'b1);
        send(8'h08, 1'b1); send(8'h5A, 1'b1);
        check("model_direct_0", 32'(mbuf[0]), 32'h41);
        check("model_direct_1", 32'(mbuf[1]), 32'h42);
        check("model_direct_2", 32'(mbuf[2]), 32'h5A);
        check("model_cursor_3", 32'(mcur), 32'd3);
        idle(70);

        // Scenario 4: direct-mode wrap
        for (int i = 0; i < 9; i++) txt[i] = 8'(8'h41 + i);
        send(8'h0D, 1'b1);
        for (int i = 0; i < 9; i++) send(txt[i], 1'b1);
        check("model_wrap_0", 32'(mbuf[0]), 32'h49);
        check("model_wrap_1", 32'(mbuf[1]), 32'h42);
        check("model_wrap_cursor", 32'(mcur), 32'd1);
        idle(70);

        // Scenario 5: clear with valid held
        send(8'h0C, 1'b1);
        @(negedge CLK); #1;
        in_if.IN_VALID = 1'b1; in_if.IN_DATA = 8'h41; in_if.MODE = 1'b1;
        lowc = 0;
        for (int k = 0; k < 20; k++) begin
            if (in_if.IN_READY) break;
            lowc++;
            @(negedge CLK); #1;
        end
        @(posedge CLK); #1 in_if.IN_VALID = 1'b0;
        check("clear_ready_low_cycles", 32'(lowc), 32'd8);
        check("model_after_clear_0", 32'(mbuf[0]), 32'h41);
        allsp = 1;
        for (int p = 1; p < DEPTH; p++) if (mbuf[p] != 7'h20) allsp = 0;
        check("model_after_clear_rest", 32'(allsp), 32'd1);
        idle(70);

        // Scenario 6: reset during STROBE, after filling the buffer
        for (int i = 0; i < 6; i++) send(8'h50 + 8'(i), 1'b0);
        waited = 0;
        @(negedge CLK);
        while (exp_wr == '1 && waited < 40) begin @(negedge CLK); waited++; end
        check("strobe_seen", 32'(exp_wr != '1), 32'd1);
        #1 RST_N = 1'b0;
        @(negedge CLK);
        check("reset_in_strobe_wr_n", 32'(HPDL_WR_N), 32'h3);
        #1 RST_N = 1'b1;
        allsp = 1;
        for (int p = 0; p < DEPTH; p++) if (mbuf[p] != 7'h20) allsp = 0;
        check("model_reset_all_space", 32'(allsp), 32'd1);
        idle(70);

        // Reset abandoning a clear
        send(8'h0C, 1'b0);
        idle(3);
        pulse_reset(2);
        idle(20);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      b = 8'($urandom_range(8'h20, 8'h7F));
            else if (r < 55) b = {1'b1, 7'($urandom_range(0, 127))};
            else if (r < 65) b = 8'h0D;
            else if (r < 75) b = 8'h08;
            else if (r < 78) b = 8'h0C;
            else if (r < 85) b = 8'($urandom_range(0, 31));
            else             b = 8'h00;
            if (r >= 85) idle($urandom_range(1, 12));
            else send(b, 1'($urandom_range(0, 1)));
            if (i % 131 == 77) pulse_reset($urandom_range(1, 3));
        end
        idle(80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
